// File: rtl/restador_serie_if.sv
// restador_serie_if: start/operand/result bundle of the bit-serial subtractor.
interface restador_serie_if #(parameter int ANCHO = 8);
  logic             inicio;
  logic [ANCHO-1:0] minuendo;
  logic [ANCHO-1:0] sustraendo;
  logic             ocupado;
  logic             listo;
  logic [ANCHO-1:0] diferencia;
  logic             prestamo_out;
  logic             cero;
  logic             desbordamiento;
  modport master (output inicio, minuendo, sustraendo,
                  input ocupado, listo, diferencia, prestamo_out, cero, desbordamiento);
  modport slave  (input inicio, minuendo, sustraendo,
                  output ocupado, listo, diferencia, prestamo_out, cero, desbordamiento);
endinterface

// File: rtl/restador_serie.sv
// restador_serie: bit-serial A-B, LSB first, one bit per clock with a borrow flip-flop.
// Optional macro RESTADOR_SATURACION_EN saturates diferencia on signed overflow.
module restador_serie #(parameter int ANCHO = 8) (
  input logic            clk,
  input logic            rst,
  restador_serie_if.slave bus
);
  localparam int CW = $clog2(ANCHO);
  typedef enum logic [1:0] {REPOSO, RESTA, FIN} estado_t;
  estado_t          estado_q, estado_d;
  logic [ANCHO-1:0] a_q, a_d, b_q, b_d, r_q, r_d, dif_q, dif_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             p_q, p_d, sa_q, sa_d, sb_q, sb_d;
  logic             prest_q, prest_d, cero_q, cero_d, desb_q, desb_d;
  logic             bit_d, p_n, desb;
  logic [ANCHO-1:0] res, res_sal;
  always_comb begin
    bit_d = a_q[0] ^ b_q[0] ^ p_q;
    p_n   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & p_q);
    res   = {bit_d, r_q[ANCHO-1:1]};
    // operand sign bits are kept aside since the shift registers lose them
    desb  = (sa_q != sb_q) & (res[ANCHO-1] != sa_q);
`ifdef RESTADOR_SATURACION_EN
    res_sal = desb ? {sa_q, {(ANCHO-1){~sa_q}}} : res;
`else
    res_sal = res;
`endif
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    p_d      = p_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    cnt_d    = cnt_q;
    dif_d    = dif_q;
    prest_d  = prest_q;
    cero_d   = cero_q;
    desb_d   = desb_q;
    case (estado_q)
      REPOSO: if (bus.inicio) begin
        estado_d = RESTA;
        a_d      = bus.minuendo;
        b_d      = bus.sustraendo;
        sa_d     = bus.minuendo[ANCHO-1];
        sb_d     = bus.sustraendo[ANCHO-1];
        p_d      = 1'b0;
        cnt_d    = '0;
      end
      RESTA: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = res;
        p_d   = p_n;
        cnt_d = cnt_q + CW'(1);
        // last bit: hold the counter instead of wrapping and load the outputs
        if (cnt_q == CW'(ANCHO-1)) begin
          estado_d = FIN;
          cnt_d    = cnt_q;
          dif_d    = res_sal;
          prest_d  = p_n;
          cero_d   = (res_sal == '0);
          desb_d   = desb;
        end
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= REPOSO;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      p_q      <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      cnt_q    <= '0;
      dif_q    <= '0;
      prest_q  <= 1'b0;
      cero_q   <= 1'b0;
      desb_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      p_q      <= p_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      cnt_q    <= cnt_d;
      dif_q    <= dif_d;
      prest_q  <= prest_d;
      cero_q   <= cero_d;
      desb_q   <= desb_d;
    end
  end
  assign bus.ocupado        = (estado_q != REPOSO);
  assign bus.listo          = (estado_q == FIN);
  assign bus.diferencia     = dif_q;
  assign bus.prestamo_out   = prest_q;
  assign bus.cero           = cero_q;
  assign bus.desbordamiento = desb_q;
endmodule

// File: tb/tb_restador_serie.sv
// tb_restador_serie: randomized and directed checks of restador_serie against an arithmetic model.
module tb_restador_serie;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int   errs = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  restador_serie_if #(.ANCHO(W)) bus();
  restador_serie #(.ANCHO(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic void modelo(input int a, input int b, output logic [W-1:0] dif,
                                 output logic p, output logic z, output logic v);
    int sa, sb, sd, r;
    sa = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sd = sa - sb;
    r  = (a - b + (1 << W)) % (1 << W);
    v  = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
    p  = a < b;
`ifdef RESTADOR_SATURACION_EN
    if (v) r = (sd > 0) ? (1 << (W-1)) - 1 : (1 << (W-1));
`endif
    dif = W'(r);
    z   = (r == 0);
  endfunction

  // Caller is at a negedge; inicio is sampled at the next edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e_dif;
    logic e_p, e_z, e_v;
    modelo(int'(a), int'(b), e_dif, e_p, e_z, e_v);
    bus.inicio = 1'b1; bus.minuendo = a; bus.sustraendo = b;
    for (int i = 1; i <= W+1; i++) begin
      @(negedge clk);
      bus.inicio = 1'b0; bus.minuendo = W'($urandom); bus.sustraendo = W'($urandom);
      checks++;
      if (bus.ocupado !== 1'b1) begin errs++; $display("FAIL ocupado %h-%h cycle %0d: got %b want 1", a, b, i, bus.ocupado); end
      checks++;
      if (bus.listo !== (i == W+1)) begin errs++; $display("FAIL listo %h-%h cycle %0d: got %b want %b", a, b, i, bus.listo, i == W+1); end
    end
    checks++;
    if (bus.diferencia !== e_dif) begin errs++; $display("FAIL diferencia %h-%h: got %h want %h", a, b, bus.diferencia, e_dif); end
    checks++;
    if (bus.prestamo_out !== e_p) begin errs++; $display("FAIL prestamo %h-%h: got %b want %b", a, b, bus.prestamo_out, e_p); end
    checks++;
    if (bus.cero !== e_z) begin errs++; $display("FAIL cero %h-%h: got %b want %b", a, b, bus.cero, e_z); end
    checks++;
    if (bus.desbordamiento !== e_v) begin errs++; $display("FAIL desbordamiento %h-%h: got %b want %b", a, b, bus.desbordamiento, e_v); end
    @(negedge clk);
    checks++;
    if (bus.ocupado !== 1'b0 || bus.listo !== 1'b0 || bus.diferencia !== e_dif)
      begin errs++; $display("FAIL hold %h-%h: ocupado=%b listo=%b dif=%h want 0 0 %h", a, b, bus.ocupado, bus.listo, bus.diferencia, e_dif); end
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.inicio = 1'b1; bus.minuendo = 8'h35; bus.sustraendo = 8'h12;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.ocupado, bus.listo, bus.diferencia, bus.prestamo_out, bus.cero, bus.desbordamiento} !== '0)
        begin errs++; $display("FAIL reset cycle %0d: got ocu=%b lis=%b dif=%h p=%b z=%b v=%b want all 0", i, bus.ocupado, bus.listo, bus.diferencia, bus.prestamo_out, bus.cero, bus.desbordamiento); end
    end
    rst = 1'b0; bus.inicio = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.ocupado !== 1'b0) begin errs++; $display("FAIL post_reset ocupado: got %b want 0", bus.ocupado); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [6] = '{8'h35, 8'h12, 8'h5A, 8'h80, 8'h7F, 8'h00};
    logic [W-1:0] vb [6] = '{8'h12, 8'h35, 8'h5A, 8'h01, 8'hFF, 8'h00};
    for (int i = 0; i < 6; i++) run_op(va[i], vb[i]);
    for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom));
  endtask

  task automatic test_back_to_back();
    int n_listo = 0;
    bus.inicio = 1'b1; bus.minuendo = 8'h10; bus.sustraendo = 8'h01;
    for (int i = 1; i <= W+2; i++) begin
      @(negedge clk);
      if (bus.listo === 1'b1) n_listo++;
      checks++;
      if (bus.ocupado !== (i <= W+1)) begin errs++; $display("FAIL b2b ocupado cycle %0d: got %b want %b", i, bus.ocupado, i <= W+1); end
      bus.inicio = (i == 3 || i == W+1);
      bus.minuendo = 8'hFF;
    end
    checks++;
    if (n_listo != 1) begin errs++; $display("FAIL b2b listo count: got %0d want 1", n_listo); end
    checks++;
    if (bus.diferencia !== 8'h0F) begin errs++; $display("FAIL b2b diferencia: got %h want 0f", bus.diferencia); end
    run_op(8'h20, 8'h05);
  endtask

  task automatic test_reset_abort();
    bus.inicio = 1'b1; bus.minuendo = 8'h35; bus.sustraendo = 8'h12;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      bus.inicio = 1'b0;
      if (i == 4) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({bus.ocupado, bus.listo, bus.diferencia, bus.prestamo_out, bus.cero, bus.desbordamiento} !== '0)
      begin errs++; $display("FAIL abort outputs: got ocu=%b lis=%b dif=%h p=%b z=%b v=%b want all 0", bus.ocupado, bus.listo, bus.diferencia, bus.prestamo_out, bus.cero, bus.desbordamiento); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (bus.listo !== 1'b0 || bus.ocupado !== 1'b0) begin errs++; $display("FAIL abort idle cycle %0d: listo=%b ocupado=%b want 0 0", i, bus.listo, bus.ocupado); end
    end
    run_op(8'h35, 8'h12);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
